// File: rtl/banco_pkg.sv
// Shared types and default dimensions for the register bank and its clear controller.
package banco_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/banco_clr_ctrl.sv
// Clear controller: after reset, walks clr_cnt over every register (one per cycle)
// while busy is high, then parks in RUN until the next reset.
module banco_clr_ctrl
  import banco_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_cnt
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              busy_nxt;

  // State, clear pointer and busy flag registers; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next state: advance the pointer each CLEAR cycle, leave after the last register.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_cnt == CNT_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == CLEAR);
  end

endmodule

// File: rtl/banco_registros_n.sv
// Two-read, one-write register bank with registered read ports, optional
// hard-wired zero register, optional write-to-read forwarding and a
// post-reset clear sweep during which requests are ignored.
module banco_registros_n
  import banco_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dir_a,
  input  logic [ADDR_W-1:0] dir_b,
  input  logic [ADDR_W-1:0] dir_wra,
  input  logic [DATA_W-1:0] di,
  input  logic              reg_rd,
  input  logic              reg_wr,
  output logic [DATA_W-1:0] doa,
  output logic [DATA_W-1:0] dob,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_cnt;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_a_c;
  logic [DATA_W-1:0] rd_b_c;

  banco_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_cnt (clr_cnt)
  );

  // A user write is effective only in RUN and never to a hard-wired zero register.
  always_comb begin
    wr_en_c = reg_wr && !busy && !(ZERO_REG && (dir_wra == '0));
  end

  // Port A read data: stored value, forwarded write data, then zero-register override.
  always_comb begin
    rd_a_c = mem[dir_a];
    if (BYPASS && wr_en_c && (dir_wra == dir_a)) begin
      rd_a_c = di;
    end
    if (ZERO_REG && (dir_a == '0)) begin
      rd_a_c = '0;
    end
  end

  // Port B read data: same selection as port A so equal addresses give equal data.
  always_comb begin
    rd_b_c = mem[dir_b];
    if (BYPASS && wr_en_c && (dir_wra == dir_b)) begin
      rd_b_c = di;
    end
    if (ZERO_REG && (dir_b == '0)) begin
      rd_b_c = '0;
    end
  end

  // Storage: the clear sweep owns the write port while busy; reset drops any write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en_c) begin
        mem[dir_wra] <= di;
      end
    end
  end

  // Read registers: zero on reset, load on reg_rd (zero while clearing), else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      doa <= '0;
      dob <= '0;
    end else if (reg_rd) begin
      if (busy) begin
        doa <= '0;
        dob <= '0;
      end else begin
        doa <= rd_a_c;
        dob <= rd_b_c;
      end
    end
  end

endmodule

// File: tb/tb_banco_registros_n.sv
// Scoreboard bench for banco_registros_n: four instances (default, no zero
// register, no bypass, 8-entry) share one directed stimulus stream.
module tb_banco_registros_n;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_rd;
  logic          reg_wr;
  logic [AW-1:0] dir_a;
  logic [AW-1:0] dir_b;
  logic [AW-1:0] dir_wra;
  logic [DW-1:0] di;
  logic [DW-1:0] doa_d, dob_d, doa_z, dob_z, doa_b, dob_b, doa_3, dob_3;
  logic          busy_d, busy_z, busy_b, busy_3;
  logic          mon_en = 1'b0;

  typedef struct {
    string         name;
    logic [DW-1:0] a_d, b_d, a_z, b_z, a_b, b_b;
    bit            chk3;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  banco_registros_n u_dflt (
    .clk(clk), .rst(rst), .dir_a(dir_a), .dir_b(dir_b), .dir_wra(dir_wra), .di(di),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .doa(doa_d), .dob(dob_d), .busy(busy_d)
  );

  banco_registros_n #(.ZERO_REG(1'b0)) u_nozero (
    .clk(clk), .rst(rst), .dir_a(dir_a), .dir_b(dir_b), .dir_wra(dir_wra), .di(di),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .doa(doa_z), .dob(dob_z), .busy(busy_z)
  );

  banco_registros_n #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .dir_a(dir_a), .dir_b(dir_b), .dir_wra(dir_wra), .di(di),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .doa(doa_b), .dob(dob_b), .busy(busy_b)
  );

  banco_registros_n #(.ADDR_W(3)) u_small (
    .clk(clk), .rst(rst), .dir_a(dir_a[2:0]), .dir_b(dir_b[2:0]), .dir_wra(dir_wra[2:0]),
    .di(di), .reg_rd(reg_rd), .reg_wr(reg_wr), .doa(doa_3), .dob(dob_3), .busy(busy_3)
  );

  function automatic exp_t mk(input string nm, input logic [DW-1:0] ad, bd, az, bz, ab, bb,
                              input bit c3);
    exp_t e;
    e.name = nm; e.a_d = ad; e.b_d = bd; e.a_z = az; e.b_z = bz; e.a_b = ab; e.b_b = bb;
    e.chk3 = c3;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected read-port state, wait past the edge.
  task automatic step(input bit r, input bit wr, input int w, input logic [DW-1:0] d,
                      input bit rd, input int a, input int b, input bit chk, input exp_t e);
    rst     = r;
    reg_wr  = wr;
    dir_wra = AW'(w);
    di      = d;
    reg_rd  = rd;
    dir_a   = AW'(a);
    dir_b   = AW'(b);
    mon_en  = rd | chk;
    if (rd | chk) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, 0, 1'b0, mk("idle", 0, 0, 0, 0, 0, 0, 1'b0));
  endtask

  task automatic chk_busy(input string tag, input int n, input bit exp_main, input bit exp_small);
    cmp($sformatf("%s[%0d].busy_dflt", tag, n), DW'(busy_d), DW'(exp_main));
    cmp($sformatf("%s[%0d].busy_nozero", tag, n), DW'(busy_z), DW'(exp_main));
    cmp($sformatf("%s[%0d].busy_nobyp", tag, n), DW'(busy_b), DW'(exp_main));
    cmp($sformatf("%s[%0d].busy_small", tag, n), DW'(busy_3), DW'(exp_small));
  endtask

  // Monitor: whenever a checked cycle's edge has passed, pop and compare all ports.
  initial begin
    exp_t e;
    bit   v;
    forever begin
      @(posedge clk);
      v = mon_en;
      @(negedge clk);
      if (v) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
          e = q.pop_front();
          cmp({e.name, ".doa_dflt"}, doa_d, e.a_d);
          cmp({e.name, ".dob_dflt"}, dob_d, e.b_d);
          cmp({e.name, ".doa_nozero"}, doa_z, e.a_z);
          cmp({e.name, ".dob_nozero"}, dob_z, e.b_z);
          cmp({e.name, ".doa_nobyp"}, doa_b, e.a_b);
          cmp({e.name, ".dob_nobyp"}, dob_b, e.b_b);
          if (e.chk3) begin
            cmp({e.name, ".doa_small"}, doa_3, e.a_d);
            cmp({e.name, ".dob_small"}, dob_3, e.b_d);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    repeat (20000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: got timeout, required stimulus completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; reg_rd = 1'b0; reg_wr = 1'b0;
    dir_a = '0; dir_b = '0; dir_wra = '0; di = '0;
    repeat (2) @(posedge clk);
    #1;

    // Clear length after reset, reads return zero throughout.
    for (int n = 0; n < 34; n++) begin
      chk_busy("rst_len", n, n < 32, n < 8);
      step(1'b0, 1'b0, 0, '0, 1'b1, n % 32, 31 - n % 32, 1'b0,
           mk("rst_rd", 0, 0, 0, 0, 0, 0, 1'b1));
    end

    // Basic write then dual read.
    step(1'b0, 1'b1, 4, 18, 1'b0, 0, 0, 1'b0, mk("w4", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b1, 5, 7, 1'b0, 0, 0, 1'b0, mk("w5", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b0, 0, '0, 1'b1, 4, 5, 1'b0, mk("wr_rd", 18, 7, 18, 7, 18, 7, 1'b1));

    // Register 0 behaviour.
    step(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, mk("w0", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b0, 0, '0, 1'b1, 0, 0, 1'b0,
         mk("zero_rd", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1));

    // Read-during-write forwarding.
    step(1'b0, 1'b1, 10, 7, 1'b0, 0, 0, 1'b0, mk("w10", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b1, 10, 9, 1'b1, 10, 4, 1'b0, mk("bypass", 9, 18, 9, 18, 7, 18, 1'b1));
    step(1'b0, 1'b0, 0, '0, 1'b1, 10, 10, 1'b0, mk("after_byp", 9, 9, 9, 9, 9, 9, 1'b1));
    step(1'b0, 1'b1, 0, 5, 1'b1, 0, 0, 1'b0, mk("byp_drop", 0, 0, 5, 5, 0, 0, 1'b1));
    step(1'b0, 1'b1, 5, 'h55, 1'b1, 4, 5, 1'b0,
         mk("byp_b", 18, 'h55, 18, 'h55, 18, 7, 1'b1));

    // Hold while reg_rd is low and r4 is rewritten.
    step(1'b0, 1'b0, 0, '0, 1'b1, 4, 5, 1'b0,
         mk("pre_hold", 18, 'h55, 18, 'h55, 18, 'h55, 1'b1));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4, DW'(100 + k), 1'b0, 0, 0, 1'b1,
           mk($sformatf("hold%0d", k), 18, 'h55, 18, 'h55, 18, 'h55, 1'b1));
    end
    step(1'b0, 1'b0, 0, '0, 1'b1, 4, 4, 1'b0,
         mk("post_hold", 102, 102, 102, 102, 102, 102, 1'b1));

    // Reset in RUN drops the write, reset mid-clear restarts the sweep.
    step(1'b0, 1'b1, 3, 'h33, 1'b0, 0, 0, 1'b0, mk("w3", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b1, 7, 'h77, 1'b0, 0, 0, 1'b0, mk("w7", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b0, 0, '0, 1'b1, 3, 7, 1'b0,
         mk("pre_clr", 'h33, 'h77, 'h33, 'h77, 'h33, 'h77, 1'b1));
    step(1'b1, 1'b1, 6, 'h66, 1'b1, 3, 7, 1'b0, mk("rst_run", 0, 0, 0, 0, 0, 0, 1'b1));
    for (int k = 0; k < 10; k++) begin
      chk_busy("clr_a", k, 1'b1, k < 8);
      step(1'b0, 1'b1, 7, DW'(32'hA0 + k), 1'b1, 7, 3, 1'b0,
           mk("clr_rd", 0, 0, 0, 0, 0, 0, 1'b0));
    end
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 0, 1'b0, mk("rst_mid", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b1, 1'b0, 0, '0, 1'b0, 0, 0, 1'b0, mk("rst_mid", 0, 0, 0, 0, 0, 0, 1'b0));
    for (int n = 0; n < 34; n++) begin
      chk_busy("clr_b", n, n < 32, n < 8);
      step(1'b0, n < 32, (n % 2 == 1) ? 7 : 3, DW'(32'hD000 + n), 1'b0, 0, 0, 1'b0,
           mk("clr_wr", 0, 0, 0, 0, 0, 0, 1'b0));
    end
    step(1'b0, 1'b0, 0, '0, 1'b1, 3, 7, 1'b0, mk("post_clr", 0, 0, 0, 0, 0, 0, 1'b0));
    step(1'b0, 1'b0, 0, '0, 1'b1, 6, 0, 1'b0, mk("rst_drop", 0, 0, 0, 0, 0, 0, 1'b0));

    repeat (3) idle();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d pending entries, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
